// File: rtl/multdiv_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit.
// One iteration per edge, WIDTH+1 edges from the start to result_rdy.
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic             result_rdy,
    output logic             exception,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t              state, state_next;
    logic [CW-1:0]       count;
    logic [2*WIDTH+1:0]  acc;
    logic [WIDTH:0]      mcand;
    logic [WIDTH-1:0]    rem, quo, dvs;
    logic                q_neg;

    logic [WIDTH:0]      booth_sum;
    logic [2*WIDTH+1:0]  acc_next;
    logic [2*WIDTH-1:0]  product;
    logic                mult_exc;
    logic [WIDTH:0]      div_shift, div_diff;
    logic [WIDTH-1:0]    rem_next, quo_next, quo_signed;
    logic [WIDTH-1:0]    a_mag, b_mag;
    logic                div_exc;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (ctrl_mult)     state_next = MULT;
                else if (ctrl_div) state_next = DIV;
            end
            MULT, DIV: if (count == LAST) state_next = DONE;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Accumulator layout {hi[WIDTH:0], lo[WIDTH-1:0], q_minus1}; the extra hi bit
    // keeps +/- most-negative multiplicand from overflowing the partial sum.
    always_comb begin
        booth_sum = acc[2*WIDTH+1:WIDTH+1];
        case (acc[1:0])
            2'b01:   booth_sum = acc[2*WIDTH+1:WIDTH+1] + mcand;
            2'b10:   booth_sum = acc[2*WIDTH+1:WIDTH+1] - mcand;
            default: booth_sum = acc[2*WIDTH+1:WIDTH+1];
        endcase
        acc_next = {booth_sum[WIDTH], booth_sum, acc[WIDTH:1]};
        product  = acc[2*WIDTH:1];
        mult_exc = !((&product[2*WIDTH-1:WIDTH-1]) || !(|product[2*WIDTH-1:WIDTH-1]));
    end

    always_comb begin
        div_shift  = {rem, quo[WIDTH-1]};
        div_diff   = div_shift - {1'b0, dvs};
        rem_next   = div_shift[WIDTH-1:0];
        quo_next   = {quo[WIDTH-2:0], 1'b0};
        if (!div_diff[WIDTH]) begin
            rem_next = div_diff[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
        quo_signed = q_neg ? ('0 - quo) : quo;
        div_exc    = (dvs == '0) || (!q_neg && quo[WIDTH-1]);
        a_mag      = operand_a[WIDTH-1] ? ('0 - operand_a) : operand_a;
        b_mag      = operand_b[WIDTH-1] ? ('0 - operand_b) : operand_b;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            result     <= '0;
            result_rdy <= 1'b0;
            exception  <= 1'b0;
            busy       <= 1'b0;
            acc        <= '0;
            mcand      <= '0;
            rem        <= '0;
            quo        <= '0;
            dvs        <= '0;
            q_neg      <= 1'b0;
        end else begin
            state      <= state_next;
            result_rdy <= 1'b0;
            busy       <= (state == MULT) || (state == DIV);
            case (state)
                IDLE: begin
                    if (ctrl_mult || ctrl_div) begin
                        count <= '0;
                        acc   <= {{(WIDTH+1){1'b0}}, operand_b, 1'b0};
                        mcand <= {operand_a[WIDTH-1], operand_a};
                        rem   <= '0;
                        quo   <= a_mag;
                        dvs   <= b_mag;
                        q_neg <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                    end
                end
                MULT: begin
                    if (count != LAST) begin
                        acc   <= acc_next;
                        count <= count + CW'(1);
                    end else begin
                        result     <= product[WIDTH-1:0];
                        exception  <= mult_exc;
                        result_rdy <= 1'b1;
                    end
                end
                DIV: begin
                    if (count != LAST) begin
                        rem   <= rem_next;
                        quo   <= quo_next;
                        count <= count + CW'(1);
                    end else begin
                        result     <= (dvs == '0) ? '0 : quo_signed;
                        exception  <= div_exc;
                        result_rdy <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
